cpld_ram_wrseq_ctrl: RTL and testbench

//  Sequencer and configuration controller for the CPC 512K expansion SRAM.

---
 rtl/cpld_ram_wrseq_ctrl_if.sv | 29 ++
 rtl/cpld_ram_wrseq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpld_ram_wrseq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpld_ram_wrseq_ctrl_if.sv
// Expansion-bus view of the 512K SRAM write sequencer: Z80 bus pins and
// mapper hint in, bank register and write-cycle gating out.
interface cpld_ram_wrseq_ctrl_if;
    logic       iorq_b;
    logic       mreq_b;
    logic       rfsh_b;
    logic       wr_b;
    logic       rd_b;
    logic       adr15;
    logic       ready;
    logic [7:0] data;
    logic       exp_sel;
    logic [5:0] ramblock;
    logic       blk_upd;
    logic       mwr_cyc;
    logic       rd_od_en;
    logic       ramoe_gate;
    logic       wr_tmo;

    modport master (
        output iorq_b, mreq_b, rfsh_b, wr_b, rd_b, adr15, ready, data, exp_sel,
        input  ramblock, blk_upd, mwr_cyc, rd_od_en, ramoe_gate, wr_tmo
    );

    modport slave (
        input  iorq_b, mreq_b, rfsh_b, wr_b, rd_b, adr15, ready, data, exp_sel,
        output ramblock, blk_upd, mwr_cyc, rd_od_en, ramoe_gate, wr_tmo
    );
endinterface

// File: rtl/cpld_ram_wrseq_ctrl.sv
// CPC 512K expansion SRAM write sequencer and bank-select register.
// Bank writes (OUT 0x7Fxx, 0b11cccbbb) are held pending and only applied
// between memory cycles so the mapper never changes mid-access.
//
//  state | meaning
//  IDLE  | no memory write in progress
//  T1    | write started, waiting for READY (timeout running)
//  T2    | READY seen, holding the write for WE_HOLD_CYC extra clocks
//  END   | write finished; a new write may start immediately
//  ABT   | write abandoned by timeout; raises wr_tmo
module cpld_ram_wrseq_ctrl #(
    parameter int unsigned WE_HOLD_CYC = 1,
    parameter int unsigned TMO_CYC     = 15,
    parameter logic [5:0]  RESET_BLOCK = 6'h00
) (
    input  logic                      clk,
    input  logic                      reset_b,
    cpld_ram_wrseq_ctrl_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_END  = 3'd3,
        S_ABT  = 3'd4
    } state_t;

    // Timeout runs as a down-counter so the terminal compare is against zero.
    localparam logic [3:0] TMO_LOAD  = 4'(TMO_CYC - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(WE_HOLD_CYC);

    state_t     state_q, state_d;
    logic       mreq_b_q, iorq_b_q, ready_q;
    logic [3:0] tmo_cnt, hold_cnt;
    logic       tmo_ld, tmo_dec, hold_ld, hold_dec, tmo_set;
    logic [5:0] ramblock_q, pend_val;
    logic       pend_q, blk_upd_q, wr_tmo_q;
    logic       wstart, cfg_hit, apply, idle_like;

    assign wstart    = !bus.mreq_b && mreq_b_q && bus.rfsh_b && bus.rd_b;
    assign cfg_hit   = !bus.iorq_b && iorq_b_q && !bus.wr_b && !bus.adr15
                       && (bus.data[7:6] == 2'b11);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_END);
    assign apply     = pend_q && idle_like && bus.mreq_b;

    // Edge-detect history for MREQ*/IORQ* and one-cycle READY synchroniser.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mreq_b_q <= 1'b1;
            iorq_b_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            mreq_b_q <= bus.mreq_b;
            iorq_b_q <= bus.iorq_b;
            ready_q  <= bus.ready;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and counter control.
    always_comb begin
        state_d  = state_q;
        tmo_ld   = 1'b0;
        tmo_dec  = 1'b0;
        hold_ld  = 1'b0;
        hold_dec = 1'b0;
        tmo_set  = 1'b0;
        unique case (state_q)
            S_IDLE, S_END: begin
                if (wstart) begin
                    state_d = S_T1;
                    tmo_ld  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T1: begin
                if (ready_q) begin
                    state_d = S_T2;
                    hold_ld = 1'b1;
                end else if (tmo_cnt == 4'd0) begin
                    state_d = S_ABT;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            S_T2: begin
                if (hold_cnt == 4'd0) state_d = S_END;
                else                  hold_dec = 1'b1;
            end
            S_ABT: begin
                tmo_set = 1'b1;
                state_d = S_END;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timeout and hold counters; both stop at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tmo_cnt  <= 4'd0;
            hold_cnt <= 4'd0;
        end else begin
            if (tmo_ld)                           tmo_cnt <= TMO_LOAD;
            else if (tmo_dec && tmo_cnt != 4'd0)  tmo_cnt <= tmo_cnt - 4'd1;
            if (hold_ld)                          hold_cnt <= HOLD_LOAD;
            else if (hold_dec && hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
        end
    end

    // Bank register capture/apply; a hit on the apply edge stays pending.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ramblock_q <= RESET_BLOCK;
            pend_val   <= 6'h00;
            pend_q     <= 1'b0;
            blk_upd_q  <= 1'b0;
            wr_tmo_q   <= 1'b0;
        end else begin
            if (cfg_hit) begin
                pend_val <= bus.data[5:0];
                pend_q   <= 1'b1;
            end else if (apply) begin
                pend_q   <= 1'b0;
            end
            if (apply) ramblock_q <= pend_val;
            blk_upd_q <= apply;
            if (apply)        wr_tmo_q <= 1'b0;
            else if (tmo_set) wr_tmo_q <= 1'b1;
        end
    end

    assign bus.mwr_cyc    = (state_q == S_T1) || (state_q == S_T2);
    assign bus.rd_od_en   = bus.mwr_cyc && bus.exp_sel;
    assign bus.ramoe_gate = bus.mwr_cyc;
    assign bus.ramblock   = ramblock_q;
    assign bus.blk_upd    = blk_upd_q;
    assign bus.wr_tmo     = wr_tmo_q;
endmodule

// File: tb/tb_cpld_ram_wrseq_ctrl.sv
// Randomised bench for the SRAM write sequencer: stimulus pushes expected
// bank updates and write-cycle shapes into queues, a monitor checks them.
module tb_cpld_ram_wrseq_ctrl;
    localparam int unsigned WE_HOLD = 1;
    localparam int unsigned TMO     = 15;
    localparam logic [5:0]  RBLK    = 6'h00;

    typedef struct {
        int len;
        bit exp;
        bit tmo;
    } wtx_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    cpld_ram_wrseq_ctrl_if bus ();

    cpld_ram_wrseq_ctrl #(.WE_HOLD_CYC(WE_HOLD), .TMO_CYC(TMO), .RESET_BLOCK(RBLK)) dut (
        .clk    (clk),
        .reset_b(reset_b),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   mwr_events = 0;
    logic [5:0] blkq[$];
    wtx_t wq[$];
    logic [5:0] m_ramblock = RBLK;
    bit   m_tmo = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: checks every write-cycle pulse and every bank update.
    bit   prev_mwr = 1'b0;
    int   mcnt = 0, rcnt = 0, ocnt = 0;
    bit   tmo_chk = 1'b0, tmo_exp = 1'b0;
    always @(negedge clk) begin
        if (!reset_b) begin
            prev_mwr = 1'b0; mcnt = 0; rcnt = 0; ocnt = 0; tmo_chk = 1'b0;
        end else begin
            if (tmo_chk) begin
                chk("wr_tmo_after_write", int'(bus.wr_tmo), int'(tmo_exp));
                tmo_chk = 1'b0;
            end
            if (bus.mwr_cyc) begin
                if (!prev_mwr) mwr_events++;
                mcnt++;
                if (bus.rd_od_en)   rcnt++;
                if (bus.ramoe_gate) ocnt++;
            end else if (prev_mwr) begin
                if (wq.size() == 0) begin
                    chk("mwr_unexpected", wq.size(), 1);
                end else begin
                    wtx_t t;
                    t = wq.pop_front();
                    chk("mwr_len", mcnt, t.len);
                    chk("rd_od_len", rcnt, t.exp ? t.len : 0);
                    chk("ramoe_len", ocnt, t.len);
                    tmo_chk = 1'b1;
                    tmo_exp = t.tmo;
                end
                mcnt = 0; rcnt = 0; ocnt = 0;
            end
            prev_mwr = bus.mwr_cyc;
            if (bus.blk_upd) begin
                if (blkq.size() == 0) begin
                    chk("blk_upd_unexpected", blkq.size(), 1);
                end else begin
                    chk("ramblock_on_upd", int'(bus.ramblock), int'(blkq.pop_front()));
                    chk("wr_tmo_cleared", int'(bus.wr_tmo), 0);
                    chk("upd_outside_write", int'(bus.mwr_cyc), 0);
                end
            end
        end
    end

    task automatic io_write(input bit a15, input logic [7:0] d);
        @(negedge clk);
        bus.iorq_b = 1'b0; bus.wr_b = 1'b0; bus.adr15 = a15; bus.data = d;
        if (!a15 && d[7:6] == 2'b11) begin
            blkq.push_back(d[5:0]);
            m_ramblock = d[5:0];
            m_tmo = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        bus.iorq_b = 1'b1; bus.wr_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("ramblock_after_out", int'(bus.ramblock), int'(m_ramblock));
    endtask

    // k = clocks after the write start edge before READY goes high.
    task automatic mem_write(input int k, input bit exp, input bit with_io, input logic [7:0] iod);
        wtx_t t;
        int   w;
        bit   to;
        to = (k + 1) > TMO;
        t.len = to ? TMO : (k + 1 + WE_HOLD + 1);
        t.exp = exp;
        m_tmo = m_tmo | to;
        t.tmo = m_tmo;
        wq.push_back(t);
        @(negedge clk);
        bus.mreq_b = 1'b1; bus.rd_b = 1'b1; bus.rfsh_b = 1'b1;
        bus.ready = (k == 0); bus.exp_sel = exp;
        @(negedge clk);
        bus.mreq_b = 1'b0; bus.wr_b = 1'b0;
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            if (with_io && j == 0) begin
                bus.iorq_b = 1'b0; bus.adr15 = 1'b0; bus.data = iod;
            end
            if (with_io && j == 1) bus.iorq_b = 1'b1;
        end
        bus.ready = 1'b1;
        if (with_io) begin
            blkq.push_back(iod[5:0]);
            m_ramblock = iod[5:0];
            m_tmo = 1'b0;
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.mwr_cyc && w < 60);
        if (bus.mwr_cyc) chk("mwr_wait_bound", int'(bus.mwr_cyc), 0);
        repeat (2) @(negedge clk);
        bus.mreq_b = 1'b1; bus.wr_b = 1'b1; bus.ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        bus.iorq_b = 1'b1; bus.mreq_b = 1'b1; bus.rfsh_b = 1'b1; bus.wr_b = 1'b1;
        bus.rd_b = 1'b1; bus.adr15 = 1'b0; bus.ready = 1'b0; bus.data = 8'h00;
        bus.exp_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ramblock", int'(bus.ramblock), int'(RBLK));
        chk("rst_outputs", int'({bus.blk_upd, bus.mwr_cyc, bus.rd_od_en, bus.ramoe_gate, bus.wr_tmo}), 0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        io_write(1'b0, 8'hC4);
        io_write(1'b0, 8'h84);
        io_write(1'b1, 8'hC4);
        mem_write(0, 1'b1, 1'b0, 8'h00);
        mem_write(20, 1'b1, 1'b0, 8'h00);
        chk("wr_tmo_sticky", int'(bus.wr_tmo), 1);
        mem_write(2, 1'b0, 1'b0, 8'h00);
        io_write(1'b0, 8'hFF);
        mem_write(4, 1'b1, 1'b1, 8'hD3);
        mem_write(14, 1'b1, 1'b0, 8'h00);

        // Refresh cycle must not start a write.
        ev = mwr_events;
        @(negedge clk);
        bus.rfsh_b = 1'b0; bus.mreq_b = 1'b0;
        repeat (4) @(negedge clk);
        chk("refresh_no_write", mwr_events, ev);
        bus.rfsh_b = 1'b1; bus.mreq_b = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
                io_write($urandom_range(0, 3) == 0, d);
            end else begin
                int  k;
                logic [7:0] d;
                k = $urandom_range(0, 18);
                d = 8'($urandom_range(0, 63)) | 8'hC0;
                mem_write(k, 1'($urandom_range(0, 1)), (k >= 2) && ($urandom_range(0, 1) == 1), d);
            end
        end

        repeat (5) @(negedge clk);
        chk("blk_queue_drained", blkq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        chk("final_ramblock", int'(bus.ramblock), int'(m_ramblock));
        chk("final_wr_tmo", int'(bus.wr_tmo), int'(m_tmo));

        // Reset while in T2 clears everything without waiting for a clock.
        @(negedge clk);
        bus.mreq_b = 1'b1; bus.ready = 1'b1; bus.exp_sel = 1'b1;
        @(negedge clk);
        bus.mreq_b = 1'b0; bus.wr_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_t2_before_reset", int'(bus.mwr_cyc), 1);
        #1 reset_b = 1'b0;
        #1;
        chk("async_rst_outputs", int'({bus.blk_upd, bus.mwr_cyc, bus.rd_od_en, bus.ramoe_gate, bus.wr_tmo}), 0);
        chk("async_rst_ramblock", int'(bus.ramblock), int'(RBLK));
        m_ramblock = RBLK; m_tmo = 1'b0;
        @(negedge clk);
        bus.mreq_b = 1'b1; bus.wr_b = 1'b1; bus.ready = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", int'(bus.mwr_cyc), 0);
        io_write(1'b0, 8'hE5);
        repeat (3) @(negedge clk);
        chk("post_reset_blk_drained", blkq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
